// File: rtl/output_channel_reservation_buffer.sv
`default_nettype none
// ============================================================================
// output_channel_reservation_buffer
//   Output FIFO whose slots are claimed ahead of time by the trigger stage and
//   filled later by the execute stage; misuse is latched in a sticky flag.
// Revision: 1.0 - initial release
// ============================================================================
module output_channel_reservation_buffer #(
  parameter int DEPTH      = 4,
  parameter int TAG_WIDTH  = 3,
  parameter int DATA_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_reserve,
  input  logic                         i_release,
  input  logic                         i_enqueue,
  input  logic [TAG_WIDTH-1:0]         i_enqueue_tag,
  input  logic [DATA_WIDTH-1:0]        i_enqueue_data,
  input  logic                         i_downstream_ready,
  output logic                         o_output_valid,
  output logic [TAG_WIDTH-1:0]         o_output_tag,
  output logic [DATA_WIDTH-1:0]        o_output_data,
  output logic                         o_full,
  output logic                         o_reserved_full,
  output logic [$clog2(DEPTH+1)-1:0]   o_occupancy,
  output logic [$clog2(DEPTH+1)-1:0]   o_reservations,
  output logic                         o_protocol_error
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int ENT_W = TAG_WIDTH + DATA_WIDTH;

  localparam logic [PTR_W-1:0] PTR_ONE   = 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = DEPTH[CNT_W-1:0];
  localparam logic [CNT_W:0]   DEPTH_SUM = DEPTH[CNT_W:0];

  logic [ENT_W-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] occ_q, occ_d;
  logic [CNT_W-1:0] res_q, res_d;
  logic             valid_q, valid_d;
  logic             full_q, full_d;
  logic             rfull_q, rfull_d;
  logic             perr_q, perr_d;

  logic             rsv_acc;
  logic             enq_acc;
  logic             rel_acc;
  logic             deq;
  logic [CNT_W-1:0] rsv_inc;
  logic [CNT_W-1:0] enq_inc;
  logic [CNT_W-1:0] rel_inc;
  logic [CNT_W-1:0] deq_inc;
  logic [CNT_W-1:0] res_after_enq;

  // Acceptance decisions look only at registered state, so every output
  // stays free of any combinational path from the inputs.
  always_comb begin
    rsv_acc       = i_reserve && !rfull_q;
    enq_acc       = i_enqueue && (res_q != '0);
    deq           = valid_q && i_downstream_ready;
    enq_inc       = {{(CNT_W-1){1'b0}}, enq_acc};
    res_after_enq = res_q - enq_inc;
    // A release cannot reclaim the reservation an enqueue is consuming.
    rel_acc       = i_release && (res_after_enq != '0);
    rsv_inc       = {{(CNT_W-1){1'b0}}, rsv_acc};
    rel_inc       = {{(CNT_W-1){1'b0}}, rel_acc};
    deq_inc       = {{(CNT_W-1){1'b0}}, deq};
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (enq_acc) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (deq) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    occ_d   = occ_q + enq_inc - deq_inc;
    res_d   = res_after_enq + rsv_inc - rel_inc;
    valid_d = (occ_d != '0);
    full_d  = (occ_d == DEPTH_CNT);
    rfull_d = (({1'b0, occ_d} + {1'b0, res_d}) == DEPTH_SUM);

    perr_d  = perr_q
            | (i_reserve && !rsv_acc)
            | (i_enqueue && !enq_acc)
            | (i_release && !rel_acc);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      res_q    <= '0;
      valid_q  <= 1'b0;
      full_q   <= 1'b0;
      rfull_q  <= 1'b0;
      perr_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      res_q    <= res_d;
      valid_q  <= valid_d;
      full_q   <= full_d;
      rfull_q  <= rfull_d;
      perr_q   <= perr_d;
    end
  end

  // Storage is not reset; valid_q gates whether the head is meaningful.
  always_ff @(posedge clk) begin
    if (enq_acc) begin
      mem_q[wr_ptr_q] <= {i_enqueue_tag, i_enqueue_data};
    end
  end

  assign o_output_valid   = valid_q;
  assign o_output_tag     = mem_q[rd_ptr_q][ENT_W-1:DATA_WIDTH];
  assign o_output_data    = mem_q[rd_ptr_q][DATA_WIDTH-1:0];
  assign o_full           = full_q;
  assign o_reserved_full  = rfull_q;
  assign o_occupancy      = occ_q;
  assign o_reservations   = res_q;
  assign o_protocol_error = perr_q;

endmodule
`default_nettype wire
